// File: rtl/osc_scheduler_if.sv
// osc_scheduler_if: valid/ready voice-config port of osc_scheduler.
// master drives cfg_valid/cfg_voice/cfg_inc/cfg_en, slave returns cfg_ready.
interface osc_scheduler_if #(
  parameter int BIT_WIDTH  = 16,
  parameter int NUM_VOICES = 4
);
  localparam int IDX_W = $clog2(NUM_VOICES);

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [IDX_W-1:0]     cfg_voice;
  logic [BIT_WIDTH-1:0] cfg_inc;
  logic                 cfg_en;

  modport master (
    output cfg_valid,
    output cfg_voice,
    output cfg_inc,
    output cfg_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_voice,
    input  cfg_inc,
    input  cfg_en,
    output cfg_ready
  );
endinterface

// File: rtl/osc_scheduler.sv
// osc_scheduler: one shared phase adder steps NUM_VOICES sawtooth voices per
// sample_tick and mixes them into a signed PCM sample (clk_audio domain).
// Ports: clk_audio, rst_n (sync, active-low), sample_tick, cfg (config
// interface, slave), sample, sample_valid, busy, overrun (sticky).
// Option: define OSC_SCHED_SATURATE_EN for full-scale clipped mixing instead
// of the averaged (acc >>> IDX_W) mix.
module osc_scheduler #(
  parameter int BIT_WIDTH  = 16,
  parameter int NUM_VOICES = 4
) (
  input  logic                 clk_audio,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  osc_scheduler_if.slave       cfg,
  output logic [BIT_WIDTH-1:0] sample,
  output logic                 sample_valid,
  output logic                 busy,
  output logic                 overrun
);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W = BIT_WIDTH + IDX_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_OUT
  } state_t;

  state_t                      r_state;
  logic [IDX_W-1:0]            r_idx;
  logic signed [ACC_W-1:0]     r_acc;
  logic [BIT_WIDTH-1:0]        r_phase [NUM_VOICES];
  logic [BIT_WIDTH-1:0]        r_inc   [NUM_VOICES];
  logic [NUM_VOICES-1:0]       r_en;

  logic                        w_cfg_fire;
  logic [BIT_WIDTH-1:0]        w_new_phase;
  logic signed [ACC_W-1:0]     w_contrib;
  logic signed [ACC_W-1:0]     w_sum;
  logic [BIT_WIDTH-1:0]        w_out;

  assign w_cfg_fire  = cfg.cfg_valid && (r_state == S_IDLE);
  assign w_new_phase = r_phase[r_idx] + r_inc[r_idx];
  // Disabled voices add nothing; enabled ones add their new phase as signed.
  assign w_contrib   = r_en[r_idx]
                     ? {{IDX_W{w_new_phase[BIT_WIDTH-1]}}, w_new_phase}
                     : '0;
  assign w_sum       = r_acc + w_contrib;

`ifdef OSC_SCHED_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(IDX_W+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(IDX_W+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

  always_comb begin
    w_out = w_sum[BIT_WIDTH-1:0];
    if (w_sum > SAT_MAX) begin
      w_out = SAT_MAX[BIT_WIDTH-1:0];
    end else if (w_sum < SAT_MIN) begin
      w_out = SAT_MIN[BIT_WIDTH-1:0];
    end
  end
`else
  // Upper slice of the sum is exactly (sum >>> IDX_W); it never clips.
  always_comb begin
    w_out = w_sum[ACC_W-1:IDX_W];
  end
`endif

  assign cfg.cfg_ready = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);

  // The last RUN step registers the mix, so sample_valid is high while the
  // FSM sits in OUT (cycle T+NUM_VOICES+1 for a tick sampled at edge T).
  always_ff @(posedge clk_audio) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_acc        <= '0;
      r_en         <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        r_phase[v] <= '0;
        r_inc[v]   <= '0;
      end
    end else begin
      sample_valid <= 1'b0;
      if (sample_tick && (r_state != S_IDLE)) begin
        overrun <= 1'b1;
      end
      if (w_cfg_fire) begin
        r_inc[cfg.cfg_voice] <= cfg.cfg_inc;
        r_en[cfg.cfg_voice]  <= cfg.cfg_en;
        if (!cfg.cfg_en) begin
          r_phase[cfg.cfg_voice] <= '0;
        end
      end
      unique case (r_state)
        S_IDLE: begin
          if (sample_tick) begin
            r_state <= S_RUN;
            r_idx   <= '0;
            r_acc   <= '0;
          end
        end
        S_RUN: begin
          if (r_en[r_idx]) begin
            r_phase[r_idx] <= w_new_phase;
          end
          r_acc <= w_sum;
          if (r_idx == LAST) begin
            r_state      <= S_OUT;
            sample       <= w_out;
            sample_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_OUT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_osc_scheduler.sv
// tb_osc_scheduler: scoreboard bench for osc_scheduler.
// Expected samples come from a voice model, queued per tick.
module tb_osc_scheduler;
  localparam int BW = 16;
  localparam int NV = 4;

  logic          clk_audio = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_tick = 1'b0;
  logic [BW-1:0] sample;
  logic          sample_valid;
  logic          busy;
  logic          overrun;

  osc_scheduler_if #(.BIT_WIDTH(BW), .NUM_VOICES(NV)) u_cfg ();

  osc_scheduler #(.BIT_WIDTH(BW), .NUM_VOICES(NV)) u_dut (
    .clk_audio    (clk_audio),
    .rst_n        (rst_n),
    .sample_tick  (sample_tick),
    .cfg          (u_cfg.slave),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk_audio = ~clk_audio;

  int n_chk = 0;
  int n_pass = 0;
  int n_valid = 0;
  int exp_q[$];

  logic [BW-1:0] m_phase [NV];
  logic [BW-1:0] m_inc   [NV];
  bit            m_en    [NV];

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = '0;
      m_inc[v]   = '0;
      m_en[v]    = 1'b0;
    end
  endtask

  task automatic push_expected();
    int acc;
    acc = 0;
    for (int v = 0; v < NV; v++) begin
      if (m_en[v]) begin
        m_phase[v] = m_phase[v] + m_inc[v];
        acc += int'($signed(m_phase[v]));
      end
    end
`ifdef OSC_SCHED_SATURATE_EN
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
    exp_q.push_back(acc);
`else
    exp_q.push_back(acc >>> 2);
`endif
  endtask

  always @(negedge clk_audio) begin
    if (sample_valid) begin
      n_valid++;
      if (exp_q.size() == 0) check("spurious_valid", 1, 0);
      else check("sample", int'($signed(sample)), exp_q.pop_front());
    end
  end

  task automatic cfg_write(int v, logic [BW-1:0] inc, bit en);
    int n;
    @(negedge clk_audio);
    u_cfg.cfg_valid = 1'b1;
    u_cfg.cfg_voice = 2'(v);
    u_cfg.cfg_inc   = inc;
    u_cfg.cfg_en    = en;
    n = 0;
    while (!u_cfg.cfg_ready && n < 20) begin
      @(negedge clk_audio);
      n++;
    end
    if (n >= 20) check("cfg_timeout", n, 0);
    m_inc[v] = inc;
    m_en[v]  = en;
    if (!en) m_phase[v] = '0;
    @(negedge clk_audio);
    u_cfg.cfg_valid = 1'b0;
  endtask

  task automatic tick_and_wait();
    int lat;
    @(negedge clk_audio);
    sample_tick = 1'b1;
    push_expected();
    @(negedge clk_audio);
    sample_tick = 1'b0;
    lat = 1;
    while (!sample_valid && lat < 20) begin
      @(negedge clk_audio);
      lat++;
    end
    check("latency", lat, NV + 1);
    @(negedge clk_audio);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int nv0;
    u_cfg.cfg_valid = 1'b0;
    u_cfg.cfg_voice = '0;
    u_cfg.cfg_inc   = '0;
    u_cfg.cfg_en    = 1'b0;
    model_reset();

    repeat (3) @(negedge clk_audio);
    rst_n = 1'b1;
    @(negedge clk_audio);
    check("rst_sample", int'(sample), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_ready", int'(u_cfg.cfg_ready), 1);

    // first pass, all voices off: timing and busy/ready windows
    @(negedge clk_audio);
    sample_tick = 1'b1;
    push_expected();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk_audio);
      if (k == 1) sample_tick = 1'b0;
      check("t1_busy", int'(busy), int'(k <= 5));
      check("t1_ready", int'(u_cfg.cfg_ready), int'(k > 5));
      check("t1_valid", int'(sample_valid), int'(k == 5));
    end

    // single voice, two passes
    cfg_write(0, 16'd500, 1'b1);
    tick_and_wait();
    tick_and_wait();

    // clear voice0 then wrap past 0x7FFF
    cfg_write(0, 16'd0, 1'b0);
    cfg_write(0, 16'h4000, 1'b1);
    tick_and_wait();
    tick_and_wait();

    // overrun tick and config held during a pass
    check("pre_overrun", int'(overrun), 0);
    nv0 = n_valid;
    @(negedge clk_audio);
    sample_tick = 1'b1;
    push_expected();
    @(negedge clk_audio);
    sample_tick = 1'b0;
    u_cfg.cfg_valid = 1'b1;
    u_cfg.cfg_voice = 2'd2;
    u_cfg.cfg_inc   = 16'd100;
    u_cfg.cfg_en    = 1'b1;
    c = 1;
    @(negedge clk_audio);
    sample_tick = 1'b1;
    c = 2;
    @(negedge clk_audio);
    sample_tick = 1'b0;
    c = 3;
    while (!u_cfg.cfg_ready && c < 20) begin
      @(negedge clk_audio);
      c++;
    end
    check("cfg_accept_cycle", c, 6);
    m_inc[2] = 16'd100;
    m_en[2]  = 1'b1;
    @(negedge clk_audio);
    u_cfg.cfg_valid = 1'b0;
    repeat (3) @(negedge clk_audio);
    check("overrun", int'(overrun), 1);
    check("one_valid", n_valid - nv0, 1);
    tick_and_wait();

    // voice1 runs, then disabling it clears its phase
    cfg_write(1, 16'd300, 1'b1);
    tick_and_wait();
    tick_and_wait();
    cfg_write(1, 16'd300, 1'b0);
    tick_and_wait();

    // reset mid-pass aborts it
    @(negedge clk_audio);
    sample_tick = 1'b1;
    push_expected();
    @(negedge clk_audio);
    sample_tick = 1'b0;
    @(negedge clk_audio);
    @(negedge clk_audio);
    rst_n = 1'b0;
    exp_q.delete();
    model_reset();
    nv0 = n_valid;
    @(negedge clk_audio);
    @(negedge clk_audio);
    rst_n = 1'b1;
    repeat (6) @(negedge clk_audio);
    check("abort_valid", n_valid - nv0, 0);
    check("abort_sample", int'(sample), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_overrun", int'(overrun), 0);
    check("abort_ready", int'(u_cfg.cfg_ready), 1);

    // four voices at 0x3000: large sums (clipped in saturating build)
    for (int v = 0; v < NV; v++) cfg_write(v, 16'h3000, 1'b1);
    tick_and_wait();
    tick_and_wait();
    tick_and_wait();

    repeat (3) @(negedge clk_audio);
    check("queue_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/osc_scheduler.md
# osc_scheduler

Time-multiplexed scheduler that shares one phase-accumulator adder among NUM_VOICES sawtooth voices, stepping every enabled voice once per audio sample. It mixes the voices into a single signed PCM sample for the downstream codec/DAC path. A valid/ready config port programs each voice's increment and enable between sample passes. All logic runs in the clk_audio domain.

## Interface
- BIT_WIDTH, 16: PCM sample width and phase-accumulator width.
- NUM_VOICES, 4: voice count; power of two, ≥2. IDX_W = $clog2(NUM_VOICES) is derived, not a parameter.
- clk_audio  in  1  audio clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- sample_tick  in  1  one-cycle strobe that starts one pass over all voices.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when high with cfg_valid.
- cfg_voice  in  IDX_W  target voice index.
- cfg_inc  in  BIT_WIDTH  per-sample phase increment, unsigned.
- cfg_en  in  1  voice enable.
- sample  out  BIT_WIDTH  signed mixed output sample.
- sample_valid  out  1  one-cycle strobe marking a new `sample`.
- busy  out  1  high while a pass is in progress.
- overrun  out  1  sticky flag: a tick arrived while busy.

## Operation
- Per-voice state: phase[v], inc[v], en[v]. All are 0 after reset.
- FSM states:
  - IDLE: sample_tick → RUN, idx=0, acc=0.
  - RUN: one voice per cycle. If en[idx], phase[idx] ← phase[idx]+inc[idx] mod 2^BIT_WIDTH, and acc ← acc + signed(new phase). If the voice is disabled, its phase is held and it contributes 0. idx==NUM_VOICES-1 → OUT; otherwise idx+1.
  - OUT: sample ← acc >>> IDX_W (arithmetic), sample_valid=1, → IDLE.
- acc width is BIT_WIDTH+IDX_W, signed; no overflow is possible.
- cfg_ready = (state==IDLE). A handshake writes inc[cfg_voice]=cfg_inc and en[cfg_voice]=cfg_en. When cfg_en=0 the write also clears phase[cfg_voice] to 0. A write with cfg_en=1 keeps the current phase.
- A handshake on the same edge as an accepted sample_tick in IDLE commits its write, and the new values apply to that pass.
- A sample_tick while in RUN or OUT is dropped and sets overrun=1. overrun clears only on reset.
- busy = (state != IDLE).

## Timing
- Reset values: sample=0, sample_valid=0, busy=0, overrun=0, state IDLE, so cfg_ready=1 from the first cycle after reset.
- Latency: tick sampled at edge T → sample_valid high in cycle T+NUM_VOICES+1, and `sample` is stable from then until the next OUT.
- Minimum tick spacing: NUM_VOICES+2 cycles.
- rst_n low mid-pass aborts the pass: no sample_valid is issued and all state clears on that edge.
- sample holds its last value while in IDLE.

## Configuration
- OSC_SCHED_SATURATE_EN:
  - Defined: OUT takes acc without the IDX_W shift and saturates it to the signed BIT_WIDTH range (0x7FFF / 0x8000 for 16 bits). This gives full-scale mixing with clipping.
  - Undefined: output is the averaged acc >>> IDX_W, which never clips.

## Test plan
Defaults BIT_WIDTH=16, NUM_VOICES=4, macro off unless stated.

1. Reset, then tick at T → sample_valid only in cycle T+5, sample=0. busy high in T+1..T+5. cfg_ready=0 during busy.
2. Voice0 inc=500 en=1, others off; two ticks → samples 125 then 250. phase[0]=1000.
3. Wrap: voice0 inc=0x4000 en=1; two ticks → phase[0]=0x8000, sample=-8192.
4. Tick at T+2 during a pass → overrun=1, exactly one sample_valid. cfg_valid held from T+1 is accepted only in the first IDLE cycle, T+6.
5. Voice1 running with phase≠0; write cfg_en=0 → phase[1]=0. Next sample excludes voice1.
6. rst_n low at T+3 → no sample_valid, all outputs at reset values. With OSC_SCHED_SATURATE_EN, four voices inc=0x3000, three ticks → phase=0x9000 each, sum=-114688, sample=0x8000.
